// File: rtl/lcd_blit_ctrl.sv
// LCD print controller: pops draw descriptors, programs the LCD window, then
// streams constant-fill or AHB-fetched packed pixels into the LCD write FIFO.
module lcd_blit_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PIX_W  = 16,
  parameter logic [7:0]  XCMD   = 8'h2A,
  parameter logic [7:0]  YCMD   = 8'h2B,
  parameter logic [7:0]  WRCMD  = 8'h2C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cmd_rdata,
  input  logic              cmd_empty,
  output logic              cmd_rinc,
  output logic [PIX_W-1:0]  lcd_wdata,
  output logic              lcd_dc,
  output logic              lcd_winc,
  input  logic              lcd_wfull,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              init_mode,
  input  logic              init_end,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int unsigned PPW    = DATA_W / PIX_W;
  localparam int unsigned SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int unsigned BYTES  = DATA_W / 8;

  typedef enum logic [3:0] {
    IDLE, HDR, POS, SIZE, SRC, INIT, WIN, FA, FD, EMIT
  } state_e;

  state_e              state_q, state_d;
  logic                blit_q, blit_d;
  logic [15:0]         colour_q, colour_d;
  logic [15:0]         x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         count_q, count_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [3:0]          idx_q, idx_d;
  logic                rdy_q, rdy_d;
  logic                done_q, done_d, err_q, err_d;
  logic [15:0]         xe, ye;
  logic [PIX_W-1:0]    pix [PPW];

  assign xe     = x0_q + w_q - 16'd1;
  assign ye     = y0_q + h_q - 16'd1;
  assign HADDR  = addr_q;
  assign HSIZE  = 3'($clog2(BYTES));
  assign HWRITE = 1'b0;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign err    = err_q;

  always_comb begin
    for (int unsigned i = 0; i < PPW; i++) pix[i] = buf_q[i*PIX_W +: PIX_W];
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      blit_q   <= 1'b0;
      colour_q <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      buf_q    <= '0;
      slot_q   <= '0;
      idx_q    <= '0;
      rdy_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      blit_q   <= blit_d;
      colour_q <= colour_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      buf_q    <= buf_d;
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    blit_d   = blit_q;
    colour_d = colour_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    addr_d   = addr_q;
    count_d  = count_q;
    buf_d    = buf_q;
    slot_d   = slot_q;
    idx_d    = idx_q;
    rdy_d    = rdy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (!cmd_empty) state_d = HDR;
      HDR: if (cmd_rinc) begin
        colour_d = cmd_rdata[15:0];
        blit_d   = (cmd_rdata[31:30] == 2'b00);
        case (cmd_rdata[31:30])
          2'b10:   state_d = INIT;
          2'b11:   begin state_d = IDLE; err_d = 1'b1; end
          default: state_d = POS;
        endcase
      end
      POS: if (cmd_rinc) begin
        x0_d    = cmd_rdata[15:0];
        y0_d    = cmd_rdata[31:16];
        state_d = SIZE;
      end
      SIZE: if (cmd_rinc) begin
        w_d     = cmd_rdata[15:0];
        h_d     = cmd_rdata[31:16];
        state_d = blit_q ? SRC : WIN;
      end
      SRC: if (cmd_rinc) begin
        addr_d  = cmd_rdata;
        state_d = WIN;
      end
      INIT: if (init_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      // First WIN cycle registers the pixel count and screens empty windows
      WIN: if (!rdy_q) begin
        count_d = 32'(w_q) * 32'(h_q);
        if (w_q == 16'd0 || h_q == 16'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          rdy_d = 1'b1;
        end
      end else if (lcd_winc) begin
        if (idx_q == 4'd10) begin
          idx_d   = 4'd0;
          rdy_d   = 1'b0;
          state_d = blit_q ? FA : EMIT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      FA: if (HREADY) state_d = FD;
      FD: if (HREADY) begin
        buf_d   = HRDATA;
        addr_d  = addr_q + 32'(BYTES);
        slot_d  = '0;
        state_d = EMIT;
      end
      EMIT: if (lcd_winc) begin
        count_d = count_q - 32'd1;
        slot_d  = slot_q + SLOT_W'(1);
        if (count_q == 32'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (blit_q && slot_q == SLOT_W'(PPW - 1)) begin
          state_d = FA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cmd_rinc  = 1'b0;
    lcd_winc  = 1'b0;
    lcd_wdata = '0;
    lcd_dc    = 1'b0;
    HTRANS    = 2'b00;
    init_mode = 1'b0;
    case (state_q)
      HDR, POS, SIZE, SRC: cmd_rinc = !cmd_empty;
      INIT: init_mode = 1'b1;
      WIN: begin
        lcd_winc = rdy_q && !lcd_wfull;
        lcd_dc   = 1'b1;
        case (idx_q)
          4'd0:    begin lcd_wdata = PIX_W'(XCMD);  lcd_dc = 1'b0; end
          4'd1:    lcd_wdata = PIX_W'(x0_q[15:8]);
          4'd2:    lcd_wdata = PIX_W'(x0_q[7:0]);
          4'd3:    lcd_wdata = PIX_W'(xe[15:8]);
          4'd4:    lcd_wdata = PIX_W'(xe[7:0]);
          4'd5:    begin lcd_wdata = PIX_W'(YCMD);  lcd_dc = 1'b0; end
          4'd6:    lcd_wdata = PIX_W'(y0_q[15:8]);
          4'd7:    lcd_wdata = PIX_W'(y0_q[7:0]);
          4'd8:    lcd_wdata = PIX_W'(ye[15:8]);
          4'd9:    lcd_wdata = PIX_W'(ye[7:0]);
          4'd10:   begin lcd_wdata = PIX_W'(WRCMD); lcd_dc = 1'b0; end
          default: lcd_wdata = '0;
        endcase
      end
      FA: HTRANS = 2'b10;
      EMIT: begin
        lcd_winc  = !lcd_wfull;
        lcd_dc    = 1'b1;
        lcd_wdata = blit_q ? pix[slot_q] : PIX_W'(colour_q);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lcd_blit_ctrl.sv
// Bench for lcd_blit_ctrl: descriptors are expanded by a transaction model into
// expected LCD pushes, AHB read addresses and completion pulses.
module tb_lcd_blit_ctrl;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PIX_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       cmd_rdata;
  logic              cmd_empty;
  logic              cmd_rinc;
  logic [PIX_W-1:0]  lcd_wdata;
  logic              lcd_dc;
  logic              lcd_winc;
  logic              lcd_wfull;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic              HWRITE;
  logic              HREADY;
  logic [DATA_W-1:0] HRDATA;
  logic              init_mode;
  logic              init_end;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  lcd_blit_ctrl dut (
    .clk(clk), .rst(rst), .cmd_rdata(cmd_rdata), .cmd_empty(cmd_empty), .cmd_rinc(cmd_rinc),
    .lcd_wdata(lcd_wdata), .lcd_dc(lcd_dc), .lcd_winc(lcd_winc), .lcd_wfull(lcd_wfull),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY),
    .HRDATA(HRDATA), .init_mode(init_mode), .init_end(init_end), .busy(busy),
    .done(done), .err(err)
  );

  typedef struct { logic [15:0] data; logic dc; bit first; int lat; } push_t;
  typedef struct { int kind; bit has_push; } end_t;   // kind: 0 done, 1 err, 2 init done

  push_t       exp_lcd[$];
  logic [31:0] exp_addr[$];
  end_t        exp_end[$];
  logic [31:0] cmdq[$];
  bit          cmd_first[$];

  int total = 0, bad = 0;
  int cyc = 0, w0_cyc = 0, last_push_cyc = -10, got_pushes = 0;
  bit lat_on = 1'b0, gap_on = 1'b0, force_wfull = 1'b0;
  int wfull_pct = 0, hready_mode = 1;
  bit dph = 1'b0;
  logic [31:0] daddr = '0;
  int fa_w = 0, fd_w = 0, init_cnt = 0, init_tgt = 2;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hBBBB_AAAA;
    if (a == 32'h104) return 32'hDDDD_CCCC;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Transaction model: what one descriptor must produce
  function automatic void model(input logic [1:0] op, input logic [15:0] col,
                                input logic [15:0] x0, input logic [15:0] y0,
                                input logic [15:0] w, input logic [15:0] h,
                                input logic [31:0] src);
    end_t e;
    push_t p;
    logic [15:0] xe, ye;
    logic [31:0] word;
    logic [7:0] win [11];
    int n;
    e.has_push = 1'b0;
    e.kind = (op == 2'b11) ? 1 : (op == 2'b10) ? 2 : 0;
    if (op[1] || w == 16'd0 || h == 16'd0) begin
      exp_end.push_back(e);
      return;
    end
    xe = x0 + w - 16'd1;
    ye = y0 + h - 16'd1;
    win = '{8'h2A, x0[15:8], x0[7:0], xe[15:8], xe[7:0],
            8'h2B, y0[15:8], y0[7:0], ye[15:8], ye[7:0], 8'h2C};
    for (int k = 0; k < 11; k++) begin
      p.data = {8'h00, win[k]};
      p.dc = !(k == 0 || k == 5 || k == 10);
      p.first = (k == 0);
      p.lat = (op == 2'b00) ? 5 : 4;
      exp_lcd.push_back(p);
    end
    n = int'(w) * int'(h);
    for (int i = 0; i < n; i++) begin
      p.dc = 1'b1;
      p.first = 1'b0;
      if (op == 2'b01) p.data = col;
      else begin
        word = mem_word(src + 32'(4 * (i / 2)));
        if (i % 2 == 0) exp_addr.push_back(src + 32'(4 * (i / 2)));
        p.data = (i % 2 == 1) ? word[31:16] : word[15:0];
      end
      exp_lcd.push_back(p);
    end
    e.has_push = 1'b1;
    exp_end.push_back(e);
  endfunction

  task automatic issue(input logic [1:0] op, input logic [15:0] col, input logic [15:0] x0,
                       input logic [15:0] y0, input logic [15:0] w, input logic [15:0] h,
                       input logic [31:0] src);
    model(op, col, x0, y0, w, h, src);
    cmdq.push_back({op, 14'($urandom), col}); cmd_first.push_back(1'b1);
    if (!op[1]) begin
      cmdq.push_back({y0, x0}); cmd_first.push_back(1'b0);
      cmdq.push_back({h, w});   cmd_first.push_back(1'b0);
      if (op == 2'b00) begin cmdq.push_back(src); cmd_first.push_back(1'b0); end
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((exp_end.size() != 0 || cmdq.size() != 0) && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("timeout_idle", 32'(exp_end.size() + cmdq.size()), 32'd0);
    check("leftover_push", 32'(exp_lcd.size()), 32'd0);
    check("leftover_addr", 32'(exp_addr.size()), 32'd0);
    @(posedge clk); #2;
  endtask

  task automatic wait_pushes(input int target);
    int n = 0;
    while (got_pushes < target && n < 2000) begin @(posedge clk); n++; end
    check("timeout_push", 32'(got_pushes >= target), 32'd1);
  endtask

  // Environment: command FIFO, AHB slave, LCD FIFO full and init sequencer
  initial begin
    cmd_empty = 1'b1; cmd_rdata = '0; lcd_wfull = 1'b0; HREADY = 1'b1; HRDATA = '0; init_end = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (cmd_rinc) begin
        check("pop_when_empty", 32'(cmd_empty), 32'd0);
        if (cmdq.size() != 0) begin
          if (cmd_first[0]) w0_cyc = cyc;
          void'(cmdq.pop_front());
          void'(cmd_first.pop_front());
        end
      end
      if (rst) dph = 1'b0;
      else begin
        if (dph && HREADY) dph = 1'b0;
        if (HTRANS == 2'b10 && HREADY) begin dph = 1'b1; daddr = HADDR; end
      end
      #1;
      cmd_empty = (cmdq.size() == 0) || (gap_on && $urandom_range(0, 3) == 0);
      cmd_rdata = (cmdq.size() != 0) ? cmdq[0] : $urandom;
      lcd_wfull = force_wfull || (wfull_pct > 0 && $urandom_range(0, 99) < wfull_pct);
      if (hready_mode == 0) HREADY = ($urandom_range(0, 99) < 70);
      else if (hready_mode == 1) HREADY = 1'b1;
      else if (HTRANS == 2'b10) begin
        HREADY = (fa_w >= 3); fa_w = (fa_w >= 3) ? 0 : fa_w + 1;
      end else if (dph) begin
        HREADY = (fd_w >= 2); fd_w = (fd_w >= 2) ? 0 : fd_w + 1;
      end else HREADY = 1'b1;
      HRDATA = (dph && HREADY) ? mem_word(daddr) : $urandom;
      if (init_mode) begin
        init_cnt++;
        init_end = (init_cnt == init_tgt);
      end else begin
        init_cnt = 0;
        init_end = 1'b0;
        init_tgt = $urandom_range(1, 4);
      end
    end
  end

  // Compare process: every cycle against the model
  initial begin
    logic [1:0]  prev_tr;
    logic        prev_rdy;
    logic [31:0] prev_addr;
    push_t p;
    end_t e;
    prev_tr = 2'b00; prev_rdy = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin prev_tr = 2'b00; continue; end
      check("htrans_legal", 32'(HTRANS == 2'b00 || HTRANS == 2'b10), 32'd1);
      if (prev_tr == 2'b10 && !prev_rdy) begin
        check("htrans_held", 32'(HTRANS), 32'h2);
        check("haddr_stable", HADDR, prev_addr);
      end
      if (prev_tr == 2'b10 && prev_rdy) check("htrans_drop", 32'(HTRANS), 32'h0);
      if (HTRANS == 2'b10 && HREADY) begin
        if (exp_addr.size() == 0) check("spurious_read", HADDR, 32'hFFFF_FFFF);
        else check("haddr", HADDR, exp_addr.pop_front());
      end
      if (lcd_winc) begin
        check("busy_on_push", 32'(busy), 32'd1);
        if (exp_lcd.size() == 0) check("spurious_push", {15'h0, lcd_dc, lcd_wdata}, 32'hFFFF_FFFF);
        else begin
          p = exp_lcd.pop_front();
          check("lcd_push", {15'h0, lcd_dc, lcd_wdata}, {15'h0, p.dc, p.data});
          if (p.first && lat_on) check("win_latency", 32'(cyc - w0_cyc + 1), 32'(p.lat));
        end
        last_push_cyc = cyc;
        got_pushes++;
      end
      if (init_mode)
        check("init_mode_owner", 32'(exp_end.size() != 0 && exp_end[0].kind == 2), 32'd1);
      if (done || err) begin
        if (exp_end.size() == 0) check("spurious_end", {30'h0, done, err}, 32'h0);
        else begin
          e = exp_end.pop_front();
          check("end_kind", {30'h0, done, err}, (e.kind == 1) ? 32'h1 : 32'h2);
          if (e.has_push) begin
            check("done_latency", 32'(cyc - last_push_cyc), 32'd1);
            check("done_all_pushed", 32'(exp_lcd.size() == 0 || exp_lcd[0].first), 32'd1);
          end
        end
      end
      prev_tr = HTRANS; prev_rdy = HREADY; prev_addr = HADDR;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rinc"}, 32'(cmd_rinc), 32'd0);
    check({tag, "_winc"}, 32'(lcd_winc), 32'd0);
    check({tag, "_dc"}, 32'(lcd_dc), 32'd0);
    check({tag, "_wdata"}, 32'(lcd_wdata), 32'd0);
    check({tag, "_init"}, 32'(init_mode), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_err"}, {30'h0, done, err}, 32'd0);
    check({tag, "_htrans"}, 32'(HTRANS), 32'd0);
    check({tag, "_haddr"}, HADDR, 32'd0);
  endtask

  initial begin
    logic [16:0] lit_fill [17];
    int base;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    check("hsize", 32'(HSIZE), 32'd2);
    check("hwrite", 32'(HWRITE), 32'd0);
    rst = 1'b0;

    // Directed fill from the worked example, model pinned by literals
    lat_on = 1'b1;
    lit_fill = '{17'h0002A, 17'h10000, 17'h10001, 17'h10000, 17'h10003, 17'h0002B,
                 17'h10000, 17'h10002, 17'h10000, 17'h10003, 17'h0002C,
                 17'h1F800, 17'h1F800, 17'h1F800, 17'h1F800, 17'h1F800, 17'h1F800};
    base = exp_lcd.size();
    issue(2'b01, 16'hF800, 16'h0001, 16'h0002, 16'h0003, 16'h0002, 32'h0);
    check("model_fill_len", 32'(exp_lcd.size() - base), 32'd17);
    for (int k = 0; k < 17; k++)
      check("model_fill_word", {15'h0, exp_lcd[base + k].dc, exp_lcd[base + k].data}, 32'(lit_fill[k]));
    wait_idle(500);

    // Directed blit, PPW=2, three pixels over two words
    base = exp_lcd.size();
    issue(2'b00, 16'h0, 16'h0010, 16'h0020, 16'h0003, 16'h0001, 32'h100);
    check("model_blit_px0", 32'(exp_lcd[base + 11].data), 32'hAAAA);
    check("model_blit_px1", 32'(exp_lcd[base + 12].data), 32'hBBBB);
    check("model_blit_px2", 32'(exp_lcd[base + 13].data), 32'hCCCC);
    check("model_blit_len", 32'(exp_lcd.size() - base), 32'd14);
    check("model_blit_a0", exp_addr[0], 32'h100);
    check("model_blit_a1", exp_addr[1], 32'h104);
    wait_idle(500);
    lat_on = 1'b0;

    // Back-pressure mid-WIN and mid-EMIT
    base = got_pushes;
    issue(2'b01, 16'h1234, 16'h00FF, 16'h0100, 16'h0004, 16'h0003, 32'h0);
    wait_pushes(base + 3);
    force_wfull = 1'b1; repeat (5) @(posedge clk); force_wfull = 1'b0;
    wait_pushes(base + 15);
    force_wfull = 1'b1; repeat (5) @(posedge clk); force_wfull = 1'b0;
    wait_idle(500);

    // AHB wait states: 3 in the address phase, 2 in the data phase
    hready_mode = 2;
    issue(2'b00, 16'h0, 16'h0000, 16'h0000, 16'h0005, 16'h0001, 32'h0000_2000);
    wait_idle(1000);
    hready_mode = 1;

    // Init, illegal, then normal descriptors and empty windows
    issue(2'b10, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 32'h0);
    issue(2'b11, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 32'h0);
    issue(2'b01, 16'h07E0, 16'hFFFE, 16'hFFFF, 16'h0003, 16'h0002, 32'h0);
    issue(2'b01, 16'h0001, 16'h0005, 16'h0005, 16'h0000, 16'h0004, 32'h0);
    issue(2'b00, 16'h0, 16'h0005, 16'h0005, 16'h0000, 16'h0002, 32'h0000_3000);
    issue(2'b01, 16'h0001, 16'h0005, 16'h0005, 16'h0002, 16'h0000, 32'h0);
    wait_idle(1000);

    // Reset in the middle of EMIT
    base = got_pushes;
    issue(2'b01, 16'hABCD, 16'h0000, 16'h0000, 16'h0008, 16'h0008, 32'h0);
    wait_pushes(base + 16);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2;
    exp_lcd.delete(); exp_addr.delete(); exp_end.delete();
    check_reset_outputs("midrst");
    rst = 1'b0;
    issue(2'b00, 16'h0, 16'h0003, 16'h0004, 16'h0002, 16'h0002, 32'h0000_4000);
    wait_idle(1000);

    // Randomized descriptor stream
    gap_on = 1'b1; wfull_pct = 25; hready_mode = 0;
    for (int d = 0; d < 40; d++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 99);
      op = (r < 40) ? 2'b00 : (r < 75) ? 2'b01 : (r < 85) ? 2'b10 : 2'b11;
      issue(op, 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom_range(0, 5)), 16'($urandom_range(0, 5)), $urandom & 32'hFFFF_FFFC);
    end
    wait_idle(30000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
